// File: rtl/key_pulse_drv.sv
// Active-low pulse driver for a panel pin: guaranteed minimum low width and
// high recovery time, with a small queue of trigger requests.
module key_pulse_drv #(
   parameter int unsigned PULSE_LEN = 20,
   parameter int unsigned GAP_LEN   = 20,
   parameter int unsigned QUEUE_MAX = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trig,
   output logic       pulse_out,
   output logic       busy,
   output logic [3:0] pending,
   output logic       drop,
   output logic       done
);

   localparam int unsigned CNT_W  = 20;
   localparam int unsigned PEND_W = 4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_GAP    = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PEND_W-1:0]   pend_q, pend_d;
   logic                pulse_q, pulse_d;
   logic                busy_q, busy_d;
   logic                drop_q, drop_d;
   logic                done_q, done_d;

   logic                pulse_last_c;
   logic                gap_last_c;
   logic                queue_full_c;

   assign pulse_last_c = (cnt_q == CNT_W'(PULSE_LEN - 1));
   assign gap_last_c   = (cnt_q == CNT_W'(GAP_LEN - 1));
   // Pending never exceeds QUEUE_MAX, so equality marks a full queue.
   assign queue_full_c = (pend_q == PEND_W'(QUEUE_MAX));

   // State register with synchronous reset; a truncated pulse is simply abandoned.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         pulse_q <= 1'b1;
         busy_q  <= 1'b0;
         drop_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         pulse_q <= pulse_d;
         busy_q  <= busy_d;
         drop_q  <= drop_d;
         done_q  <= done_d;
      end
   end

   // Next-state, counter, queue and registered output values.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      drop_d  = 1'b0;
      done_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (trig) begin
               state_d = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (pulse_last_c) begin
               state_d = S_GAP;
               cnt_d   = '0;
            end
            if (trig) begin
               if (queue_full_c) drop_d = 1'b1;
               else              pend_d = pend_q + PEND_W'(1);
            end
         end
         S_GAP: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (gap_last_c) begin
               done_d = 1'b1;
               cnt_d  = '0;
               // A queued request is consumed; a coincident trig refills its slot.
               if (pend_q != '0) begin
                  state_d = S_ACTIVE;
                  if (!trig) pend_d = pend_q - PEND_W'(1);
               end else if (trig) begin
                  state_d = S_ACTIVE;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (trig) begin
               if (queue_full_c) drop_d = 1'b1;
               else              pend_d = pend_q + PEND_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      pulse_d = (state_d != S_ACTIVE);
      busy_d  = (state_d != S_IDLE);
   end

   assign pulse_out = pulse_q;
   assign busy      = busy_q;
   assign pending   = pend_q;
   assign drop      = drop_q;
   assign done      = done_q;

endmodule

// File: tb/tb_key_pulse_drv.sv
// Directed bench for key_pulse_drv: one instance with QUEUE_MAX=2 and one with
// QUEUE_MAX=0, both PULSE_LEN=4, GAP_LEN=3, sharing clk/rst/trig.
module tb_key_pulse_drv;

   logic       clk;
   logic       rst;
   logic       trig;

   logic       p2_pulse, p2_busy, p2_drop, p2_done;
   logic [3:0] p2_pend;
   logic       p0_pulse, p0_busy, p0_drop, p0_done;
   logic [3:0] p0_pend;

   int checks = 0;
   int errors = 0;

   key_pulse_drv #(.PULSE_LEN(4), .GAP_LEN(3), .QUEUE_MAX(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .trig      (trig),
      .pulse_out (p2_pulse),
      .busy      (p2_busy),
      .pending   (p2_pend),
      .drop      (p2_drop),
      .done      (p2_done)
   );

   key_pulse_drv #(.PULSE_LEN(4), .GAP_LEN(3), .QUEUE_MAX(0)) dut_q0 (
      .clk       (clk),
      .rst       (rst),
      .trig      (trig),
      .pulse_out (p0_pulse),
      .busy      (p0_busy),
      .pending   (p0_pend),
      .drop      (p0_drop),
      .done      (p0_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive inputs for the coming edge, then sample just after that edge.
   task automatic step(input logic t, input logic r);
      trig = t;
      rst  = r;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int o, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s@%0d observed=%0d expected=%0d", tag, o, obs, exp);
      end
   endtask

   task automatic chk2(input int o, input int ep, input int eb, input int epend,
                       input int edrop, input int edone);
      chk("q2.pulse_out", o, int'(p2_pulse), ep);
      chk("q2.busy",      o, int'(p2_busy),  eb);
      chk("q2.pending",   o, int'(p2_pend),  epend);
      chk("q2.drop",      o, int'(p2_drop),  edrop);
      chk("q2.done",      o, int'(p2_done),  edone);
   endtask

   function automatic bit in3(input int o);
      return (o >= 11 && o <= 14) || (o >= 18 && o <= 21) || (o >= 25 && o <= 28);
   endfunction

   initial begin
      trig = 1'b0;
      rst  = 1'b1;

      // Reset held 3 cycles with trig toggling
      for (int i = 0; i < 3; i++) begin
         step(i[0] ? 1'b0 : 1'b1, 1'b1);
         chk2(i, 1, 0, 0, 0, 0);
         chk("q0.pulse_out", i, int'(p0_pulse), 1);
         chk("q0.busy",      i, int'(p0_busy),  0);
      end
      step(1'b0, 1'b0);
      chk2(3, 1, 0, 0, 0, 0);

      // Single pulse: trig sampled at edge 10, observe cycles 11..20
      for (int e = 10; e <= 19; e++) begin
         int o;
         o = e + 1;
         step(e == 10, 1'b0);
         chk2(o, (o >= 11 && o <= 14) ? 0 : 1, (o >= 11 && o <= 17) ? 1 : 0,
              0, 0, (o == 18) ? 1 : 0);
      end

      // Queueing: trigs at 10, 12, 13
      for (int e = 10; e <= 33; e++) begin
         int o, ep;
         o = e + 1;
         step(e == 10 || e == 12 || e == 13, 1'b0);
         ep = (o < 13) ? 0 : (o == 13) ? 1 : (o <= 17) ? 2 : (o <= 24) ? 1 : 0;
         chk2(o, in3(o) ? 0 : 1, (o >= 11 && o <= 31) ? 1 : 0, ep, 0,
              (o == 18 || o == 25 || o == 32) ? 1 : 0);
         chk("q0.pulse_out", o, int'(p0_pulse), (o >= 11 && o <= 14) ? 0 : 1);
         chk("q0.drop",      o, int'(p0_drop),  (o == 13 || o == 14) ? 1 : 0);
         chk("q0.pending",   o, int'(p0_pend),  0);
      end

      // Overflow: trigs at 10..13, queue saturates at 2
      for (int e = 10; e <= 33; e++) begin
         int o, ep;
         o = e + 1;
         step(e >= 10 && e <= 13, 1'b0);
         ep = (o < 12) ? 0 : (o == 12) ? 1 : (o <= 17) ? 2 : (o <= 24) ? 1 : 0;
         chk2(o, in3(o) ? 0 : 1, (o >= 11 && o <= 31) ? 1 : 0, ep,
              (o == 14) ? 1 : 0, (o == 18 || o == 25 || o == 32) ? 1 : 0);
         chk("q0.drop", o, int'(p0_drop), (o >= 12 && o <= 14) ? 1 : 0);
      end

      // Enqueue coinciding with GAP-final dequeue (edge 17)
      for (int e = 10; e <= 33; e++) begin
         int o, ep;
         o = e + 1;
         step(e == 10 || e == 12 || e == 17, 1'b0);
         ep = (o < 13) ? 0 : (o <= 24) ? 1 : 0;
         chk2(o, in3(o) ? 0 : 1, (o >= 11 && o <= 31) ? 1 : 0, ep, 0,
              (o == 18 || o == 25 || o == 32) ? 1 : 0);
         chk("q0.pulse_out", o, int'(p0_pulse),
             ((o >= 11 && o <= 14) || (o >= 18 && o <= 21)) ? 0 : 1);
         chk("q0.pending",   o, int'(p0_pend), 0);
         chk("q0.done",      o, int'(p0_done), (o == 18 || o == 25) ? 1 : 0);
      end

      // Reset mid-pulse at edge 12 with one request queued
      for (int e = 10; e <= 30; e++) begin
         int o;
         o = e + 1;
         step(e == 10 || e == 11, e == 12);
         if (o <= 12)
            chk2(o, 0, 1, (o == 12) ? 1 : 0, 0, 0);
         else
            chk2(o, 1, 0, 0, 0, 0);
      end
      step(1'b1, 1'b0);
      chk2(32, 0, 1, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
